// File: rtl/axi4_lite_interconnect_nslave.sv
// rtl/axi4_lite_interconnect_nslave.sv - 1-master / N-slave AXI4-Lite interconnect with decode, DECERR and timeout SLVERR
//
// Purpose: routes a single AXI4-Lite master to one of N_SLAVE peripherals chosen by
// per-slave base/mask windows. Only one transaction is in flight at a time. When a
// read and a write are both pending, they are granted alternately. Unmapped addresses
// are answered locally with DECERR. A slave that never returns RVALID/BVALID is
// answered with SLVERR after TIMEOUT_CYC cycles.
//
// Ports:
//   axi_aclk_i / axi_areset_i          clock, asynchronous active-high reset
//   s_ar* / s_r*                       master read address / read data channels
//   s_aw* / s_w* / s_b*                master write address / data / response channels
//   read_size_i / m_read_size_o        read size, forwarded unchanged
//   m_araddr_o m_awaddr_o m_wdata_o m_wstrb_o   broadcast to all slaves
//   m_*valid_o / m_*ready_o            one-hot per-slave strobes
//   m_*ready_i / m_*valid_i            per-slave handshakes
//   m_rdata_i m_rresp_i m_bresp_i      packed per-slave read data and responses
module axi4_lite_interconnect_nslave #(
  parameter int                        N_SLAVE     = 3,
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter logic [N_SLAVE*ADDR_W-1:0] SLAVE_BASE  = '0,
  parameter logic [N_SLAVE*ADDR_W-1:0] SLAVE_MASK  = {N_SLAVE{32'hFFFF_F000}},
  parameter int                        TIMEOUT_CYC = 255
) (
  input  logic                     axi_aclk_i,
  input  logic                     axi_areset_i,
  input  logic [ADDR_W-1:0]        s_araddr_i,
  input  logic                     s_arvalid_i,
  output logic                     s_arready_o,
  output logic [DATA_W-1:0]        s_rdata_o,
  output logic [1:0]               s_rresp_o,
  output logic                     s_rvalid_o,
  input  logic                     s_rready_i,
  input  logic [ADDR_W-1:0]        s_awaddr_i,
  input  logic                     s_awvalid_i,
  output logic                     s_awready_o,
  input  logic [DATA_W-1:0]        s_wdata_i,
  input  logic [DATA_W/8-1:0]      s_wstrb_i,
  input  logic                     s_wvalid_i,
  output logic                     s_wready_o,
  output logic [1:0]               s_bresp_o,
  output logic                     s_bvalid_o,
  input  logic                     s_bready_i,
  input  logic [3:0]               read_size_i,
  output logic [ADDR_W-1:0]        m_araddr_o,
  output logic [ADDR_W-1:0]        m_awaddr_o,
  output logic [DATA_W-1:0]        m_wdata_o,
  output logic [DATA_W/8-1:0]      m_wstrb_o,
  output logic [3:0]               m_read_size_o,
  output logic [N_SLAVE-1:0]       m_arvalid_o,
  output logic [N_SLAVE-1:0]       m_rready_o,
  output logic [N_SLAVE-1:0]       m_awvalid_o,
  output logic [N_SLAVE-1:0]       m_wvalid_o,
  output logic [N_SLAVE-1:0]       m_bready_o,
  input  logic [N_SLAVE-1:0]       m_arready_i,
  input  logic [N_SLAVE-1:0]       m_rvalid_i,
  input  logic [N_SLAVE-1:0]       m_awready_i,
  input  logic [N_SLAVE-1:0]       m_wready_i,
  input  logic [N_SLAVE-1:0]       m_bvalid_i,
  input  logic [N_SLAVE*DATA_W-1:0] m_rdata_i,
  input  logic [N_SLAVE*2-1:0]     m_rresp_i,
  input  logic [N_SLAVE*2-1:0]     m_bresp_i
);

  localparam int               SEL_W       = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int               CNT_W       = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] TMO_MAX     = CNT_W'(TIMEOUT_CYC);
  localparam logic [1:0]       RESP_SLVERR = 2'b10;
  localparam logic [1:0]       RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_A, WR_B, ERR_R, ERR_B} state_t;

  state_t           state, state_nxt;
  logic [SEL_W-1:0] sel;
  logic [ADDR_W-1:0] addr_q;
  logic             aw_done, w_done;
  logic             err_rsp;   // error states: 0 = accept address, 1 = return response
  logic             prio_wr;   // 1 = write wins the next read/write contention
  logic [CNT_W-1:0] tmo_cnt;

  logic             rd_hit, wr_hit;
  logic [SEL_W-1:0] rd_idx, wr_idx;
  logic             wr_req, grant_rd, grant_wr, timed_out, slv_valid;

  // Scan from the top index down so the lowest matching window wins on overlap.
  always_comb begin
    rd_hit = 1'b0;
    rd_idx = '0;
    wr_hit = 1'b0;
    wr_idx = '0;
    for (int i = N_SLAVE - 1; i >= 0; i--) begin
      if ((s_araddr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        rd_hit = 1'b1;
        rd_idx = SEL_W'(i);
      end
      if ((s_awaddr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
        wr_hit = 1'b1;
        wr_idx = SEL_W'(i);
      end
    end
  end

  assign wr_req    = s_awvalid_i & s_wvalid_i;
  assign grant_rd  = s_arvalid_i & (~wr_req | ~prio_wr);
  assign grant_wr  = wr_req & (~s_arvalid_i | prio_wr);
  assign timed_out = (TIMEOUT_CYC != 0) && (tmo_cnt == TMO_MAX);
  assign slv_valid = (state == RD_D) ? m_rvalid_i[sel] : m_bvalid_i[sel];

  assign m_araddr_o    = addr_q;
  assign m_awaddr_o    = addr_q;
  assign m_wdata_o     = s_wdata_i;
  assign m_wstrb_o     = s_wstrb_i;
  assign m_read_size_o = read_size_i;

  always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
    if (axi_areset_i) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_rd)      state_nxt = rd_hit ? RD_A : ERR_R;
        else if (grant_wr) state_nxt = wr_hit ? WR_A : ERR_B;
      end
      RD_A:  if (m_arready_i[sel]) state_nxt = RD_D;
      RD_D:  if ((timed_out | m_rvalid_i[sel]) & s_rready_i) state_nxt = IDLE;
      WR_A:  if ((aw_done | m_awready_i[sel]) & (w_done | m_wready_i[sel])) state_nxt = WR_B;
      WR_B:  if ((timed_out | m_bvalid_i[sel]) & s_bready_i) state_nxt = IDLE;
      ERR_R: if (err_rsp & s_rready_i) state_nxt = IDLE;
      ERR_B: if (err_rsp & s_bready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk_i or posedge axi_areset_i) begin
    if (axi_areset_i) begin
      sel     <= '0;
      addr_q  <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      err_rsp <= 1'b0;
      prio_wr <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
        err_rsp <= 1'b0;
        if (grant_rd) begin
          sel    <= rd_idx;
          addr_q <= s_araddr_i;
        end else if (grant_wr) begin
          sel    <= wr_idx;
          addr_q <= s_awaddr_i;
        end
        if (s_arvalid_i & wr_req) prio_wr <= ~prio_wr;
      end
      if (state == WR_A) begin
        if (m_awready_i[sel]) aw_done <= 1'b1;
        if (m_wready_i[sel])  w_done  <= 1'b1;
      end
      if (state == ERR_R || state == ERR_B) err_rsp <= 1'b1;
      // Cleared on every state change; saturates at TMO_MAX instead of wrapping.
      if (state_nxt != state) begin
        tmo_cnt <= '0;
      end else if ((state == RD_D || state == WR_B) && !slv_valid && !timed_out && TIMEOUT_CYC != 0) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    s_arready_o = 1'b0;
    s_rvalid_o  = 1'b0;
    s_rdata_o   = '0;
    s_rresp_o   = '0;
    s_awready_o = 1'b0;
    s_wready_o  = 1'b0;
    s_bvalid_o  = 1'b0;
    s_bresp_o   = '0;
    m_arvalid_o = '0;
    m_rready_o  = '0;
    m_awvalid_o = '0;
    m_wvalid_o  = '0;
    m_bready_o  = '0;
    case (state)
      RD_A: begin
        m_arvalid_o[sel] = 1'b1;
        s_arready_o      = m_arready_i[sel];
      end
      RD_D: begin
        // Once timed out the stuck slave is cut off: its late RVALID never reaches the master.
        if (timed_out) begin
          s_rvalid_o = 1'b1;
          s_rresp_o  = RESP_SLVERR;
        end else begin
          s_rvalid_o      = m_rvalid_i[sel];
          s_rdata_o       = m_rdata_i[sel*DATA_W +: DATA_W];
          s_rresp_o       = m_rresp_i[sel*2 +: 2];
          m_rready_o[sel] = s_rready_i;
        end
      end
      WR_A: begin
        m_awvalid_o[sel] = ~aw_done;
        m_wvalid_o[sel]  = ~w_done;
        s_awready_o      = ~aw_done & m_awready_i[sel];
        s_wready_o       = ~w_done & m_wready_i[sel];
      end
      WR_B: begin
        if (timed_out) begin
          s_bvalid_o = 1'b1;
          s_bresp_o  = RESP_SLVERR;
        end else begin
          s_bvalid_o      = m_bvalid_i[sel];
          s_bresp_o       = m_bresp_i[sel*2 +: 2];
          m_bready_o[sel] = s_bready_i;
        end
      end
      ERR_R: begin
        if (!err_rsp) begin
          s_arready_o = 1'b1;
        end else begin
          s_rvalid_o = 1'b1;
          s_rresp_o  = RESP_DECERR;
        end
      end
      ERR_B: begin
        if (!err_rsp) begin
          s_awready_o = 1'b1;
          s_wready_o  = 1'b1;
        end else begin
          s_bvalid_o = 1'b1;
          s_bresp_o  = RESP_DECERR;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi4_lite_interconnect_nslave.sv
// tb/tb_axi4_lite_interconnect_nslave.sv - self-checking bench for axi4_lite_interconnect_nslave
module tb_axi4_lite_interconnect_nslave;

  localparam int BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [3:0]  read_size = 4'h2;
  logic [31:0] m_araddr, m_awaddr, m_wdata;
  logic [3:0]  m_wstrb, m_read_size;
  logic [2:0]  m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic [2:0]  m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [95:0] m_rdata;
  logic [5:0]  m_rresp, m_bresp;

  int checks = 0;
  int errors = 0;

  logic [33:0] rd_q[$];
  logic [1:0]  wr_q[$];

  logic [2:0]  rpend, bpend;
  int          rcnt[3], wcnt[3];
  int          r_delay[3];
  int          w_lag = 0;
  logic        slv_flush = 1'b0;
  logic [31:0] slv_rdata[3];
  logic [31:0] wmem[3];

  always #5 clk = ~clk;

  axi4_lite_interconnect_nslave #(
    .N_SLAVE(3), .ADDR_W(32), .DATA_W(32),
    .SLAVE_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000}),
    .SLAVE_MASK({3{32'hFFFF_F000}}),
    .TIMEOUT_CYC(4)
  ) dut (
    .axi_aclk_i(clk), .axi_areset_i(rst),
    .s_araddr_i(s_araddr), .s_arvalid_i(s_arvalid), .s_arready_o(s_arready),
    .s_rdata_o(s_rdata), .s_rresp_o(s_rresp), .s_rvalid_o(s_rvalid), .s_rready_i(s_rready),
    .s_awaddr_i(s_awaddr), .s_awvalid_i(s_awvalid), .s_awready_o(s_awready),
    .s_wdata_i(s_wdata), .s_wstrb_i(s_wstrb), .s_wvalid_i(s_wvalid), .s_wready_o(s_wready),
    .s_bresp_o(s_bresp), .s_bvalid_o(s_bvalid), .s_bready_i(s_bready),
    .read_size_i(read_size),
    .m_araddr_o(m_araddr), .m_awaddr_o(m_awaddr), .m_wdata_o(m_wdata), .m_wstrb_o(m_wstrb),
    .m_read_size_o(m_read_size),
    .m_arvalid_o(m_arvalid), .m_rready_o(m_rready), .m_awvalid_o(m_awvalid),
    .m_wvalid_o(m_wvalid), .m_bready_o(m_bready),
    .m_arready_i(m_arready), .m_rvalid_i(m_rvalid), .m_awready_i(m_awready),
    .m_wready_i(m_wready), .m_bvalid_i(m_bvalid),
    .m_rdata_i(m_rdata), .m_rresp_i(m_rresp), .m_bresp_i(m_bresp)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Slave models: slot 0 answers reads with EXOKAY so response forwarding is visible.
  assign m_rresp = 6'b00_00_01;
  assign m_bresp = 6'b00_00_00;

  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    m_awready = '0;
    m_wready  = '0;
    m_rdata   = '0;
    for (int i = 0; i < 3; i++) begin
      m_arready[i]      = m_arvalid[i];
      m_rvalid[i]       = rpend[i] && (rcnt[i] == 0);
      m_awready[i]      = m_awvalid[i];
      m_wready[i]       = m_wvalid[i] && (wcnt[i] >= w_lag);
      m_rdata[i*32+:32] = slv_rdata[i];
    end
  end
  assign m_bvalid = bpend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rpend <= '0;
      bpend <= '0;
      for (int i = 0; i < 3; i++) begin
        rcnt[i] <= 0;
        wcnt[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (slv_flush) rpend[i] <= 1'b0;
        else if (m_arvalid[i] && m_arready[i]) begin
          rpend[i] <= 1'b1;
          rcnt[i]  <= r_delay[i];
        end else if (rpend[i] && rcnt[i] != 0) rcnt[i] <= rcnt[i] - 1;
        else if (m_rvalid[i] && m_rready[i]) rpend[i] <= 1'b0;
        if (m_wvalid[i] && m_wready[i]) begin
          wcnt[i]  <= 0;
          bpend[i] <= 1'b1;
          wmem[i]  <= m_wdata;
        end else if (m_wvalid[i]) wcnt[i] <= wcnt[i] + 1;
        if (m_bvalid[i] && m_bready[i]) bpend[i] <= 1'b0;
      end
    end
  end

  // Master-side scoreboard and strobe one-hot monitor.
  always @(negedge clk) begin
    if (!rst) begin
      check("onehot", {63'd0, ($countones(m_arvalid) <= 1) && ($countones(m_rready) <= 1) &&
                              ($countones(m_awvalid) <= 1) && ($countones(m_wvalid) <= 1) &&
                              ($countones(m_bready) <= 1)}, 64'd1);
      if (s_rvalid && s_rready) begin
        if (rd_q.size() == 0) check("r_extra", 1, 0);
        else begin
          logic [33:0] e;
          e = rd_q.pop_front();
          check("rdata", s_rdata, e[31:0]);
          check("rresp", s_rresp, e[33:32]);
        end
      end
      if (s_bvalid && s_bready) begin
        if (wr_q.size() == 0) check("b_extra", 1, 0);
        else check("bresp", s_bresp, wr_q.pop_front());
      end
    end
  end

  task automatic xfer(input logic rd, input logic [31:0] ra, input logic wr, input logic [31:0] wa,
                      input logic [31:0] wd, output logic [2:0] ar_oh, output logic [2:0] aw_oh,
                      output int r_lat, output int b_lat, output logic split);
    @(negedge clk);
    s_araddr = ra; s_arvalid = rd;
    s_awaddr = wa; s_awvalid = wr;
    s_wdata = wd; s_wstrb = 4'hF; s_wvalid = wr;
    ar_oh = '0; aw_oh = '0; r_lat = -1; b_lat = -1; split = 1'b0;
    for (int n = 1; n <= BUDGET; n++) begin
      logic ar_acc, aw_acc, w_acc;
      @(negedge clk);
      if (n == 1) begin
        ar_oh = m_arvalid;
        aw_oh = m_awvalid;
      end
      if (s_rvalid && r_lat < 0) r_lat = n;
      if (s_bvalid && b_lat < 0) b_lat = n;
      if (m_awvalid == 3'b000 && m_wvalid != 3'b000) split = 1'b1;
      ar_acc = s_arvalid && s_arready;
      aw_acc = s_awvalid && s_awready;
      w_acc  = s_wvalid && s_wready;
      if (!s_arvalid && !s_awvalid && !s_wvalid && rd_q.size() == 0 && wr_q.size() == 0) return;
      @(posedge clk);
      #1;
      if (ar_acc) s_arvalid = 1'b0;
      if (aw_acc) s_awvalid = 1'b0;
      if (w_acc)  s_wvalid = 1'b0;
    end
    check("xfer_budget", 1, 0);
    s_arvalid = 1'b0; s_awvalid = 1'b0; s_wvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] ar_oh, aw_oh;
    int         r_lat, b_lat;
    logic       split;

    r_delay[0] = 0; r_delay[1] = 0; r_delay[2] = 0;
    slv_rdata[0] = 32'hA5A5_0001;
    slv_rdata[1] = 32'h1234_5678;
    slv_rdata[2] = 32'h3333_4444;
    repeat (3) @(negedge clk);
    check("rst_arready", s_arready, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_m_valid", {m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready}, 0);
    rst = 1'b0;
    check("read_size", m_read_size, 4'h2);

    rd_q.push_back({2'b00, 32'h1234_5678});
    xfer(1, 32'h2000_0004, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("spi_ar_oh", ar_oh, 3'b010);
    check("spi_r_lat", r_lat, 2);

    rd_q.push_back({2'b01, 32'hA5A5_0001});
    xfer(1, 32'h1000_0010, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("uart_ar_oh", ar_oh, 3'b001);

    rd_q.push_back({2'b11, 32'h0});
    xfer(1, 32'h4000_0000, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("decerr_r_oh", ar_oh, 3'b000);
    check("decerr_r_lat", r_lat, 2);

    wr_q.push_back(2'b00);
    xfer(0, 0, 1, 32'h3000_0008, 32'hCAFE_F00D, ar_oh, aw_oh, r_lat, b_lat, split);
    check("pwm_aw_oh", aw_oh, 3'b100);
    check("pwm_b_lat", b_lat, 2);
    check("pwm_split", split, 0);
    check("pwm_wdata", wmem[2], 32'hCAFE_F00D);

    wr_q.push_back(2'b11);
    xfer(0, 0, 1, 32'hDEAD_0000, 32'h5555_AAAA, ar_oh, aw_oh, r_lat, b_lat, split);
    check("decerr_w_oh", aw_oh, 3'b000);
    check("decerr_b_lat", b_lat, 2);

    w_lag = 1;
    wr_q.push_back(2'b00);
    xfer(0, 0, 1, 32'h2000_0010, 32'h0BAD_CAFE, ar_oh, aw_oh, r_lat, b_lat, split);
    check("lag_split", split, 1);
    check("lag_b_lat", b_lat, 3);
    check("lag_wdata", wmem[1], 32'h0BAD_CAFE);
    w_lag = 0;

    slv_rdata[1] = 32'h1111_2222;
    rd_q.push_back({2'b00, 32'h1111_2222});
    wr_q.push_back(2'b00);
    xfer(1, 32'h2000_0000, 1, 32'h1000_0000, 32'h0000_0C01, ar_oh, aw_oh, r_lat, b_lat, split);
    check("cont1_ar_oh", ar_oh, 3'b010);
    check("cont1_aw_oh", aw_oh, 3'b000);
    check("cont1_wdata", wmem[0], 32'h0000_0C01);

    rd_q.push_back({2'b00, 32'h3333_4444});
    wr_q.push_back(2'b00);
    xfer(1, 32'h3000_0000, 1, 32'h1000_0004, 32'h0000_0C02, ar_oh, aw_oh, r_lat, b_lat, split);
    check("cont2_ar_oh", ar_oh, 3'b000);
    check("cont2_aw_oh", aw_oh, 3'b001);
    check("cont2_wdata", wmem[0], 32'h0000_0C02);

    // PWM raises RVALID in the same cycle the timeout expires; that late beat must not leak through.
    r_delay[2] = 4;
    slv_rdata[2] = 32'hBAD0_BAD0;
    rd_q.push_back({2'b10, 32'h0});
    xfer(1, 32'h3000_0000, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("tmo_r_lat", r_lat, 6);
    @(negedge clk);
    slv_flush = 1'b1;
    @(negedge clk);
    slv_flush = 1'b0;
    rd_q.push_back({2'b00, 32'h1111_2222});
    xfer(1, 32'h2000_0008, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("post_tmo_r_lat", r_lat, 2);

    r_delay[0] = 3;
    @(negedge clk);
    s_araddr = 32'h1000_0000;
    s_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 s_arvalid = 1'b0;
    @(negedge clk);
    check("rdd_rready", m_rready, 3'b001);
    rst = 1'b1;
    #1;
    check("arst_rready", m_rready, 3'b000);
    check("arst_rvalid", s_rvalid, 0);
    check("arst_arready", s_arready, 0);
    check("arst_m_valid", {m_arvalid, m_awvalid, m_wvalid}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    rd_q.push_back({2'b01, 32'hA5A5_0001});
    xfer(1, 32'h1000_0000, 0, 0, 0, ar_oh, aw_oh, r_lat, b_lat, split);
    check("post_rst_ar_oh", ar_oh, 3'b001);
    check("post_rst_r_lat", r_lat, 5);

    repeat (3) @(negedge clk);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
